// File: rtl/harvos_satp_update_ctrl.sv
// satp CSR write controller: drains in-flight memory ops and flushes the TLB before committing a
// new satp value. Optional build macro HARVOS_SATP_FLUSH_ELIDE_EN skips drain/flush on rewrites.
module harvos_satp_update_ctrl #(
  parameter logic [31:0] RESET_SATP     = 32'h8000_0000,
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        wr_valid,
  output logic        wr_ready,
  input  logic [31:0] wr_data,
  output logic        wr_done,
  output logic        wr_reject,
  output logic        drain_req,
  input  logic        drain_ack,
  output logic        flush_req,
  input  logic        flush_ack,
  output logic [31:0] csr_satp_q,
  output logic        busy,
  output logic        timeout_err
);

  typedef enum logic [1:0] {StIdle, StDrain, StFlush, StCommit} state_e;

  // Counter value on the last allowed wait cycle of a phase.
  localparam logic [15:0] WaitLimit = 16'(TIMEOUT_CYCLES - 1);

  state_e      state_q, state_d;
  logic [31:0] pending_q, pending_d;
  logic [31:0] csr_d;
  logic [15:0] wait_cnt_q, wait_cnt_d;
  logic        wr_done_q, wr_done_d;
  logic        wr_reject_q, wr_reject_d;
  logic        timeout_err_q, timeout_err_d;
  logic        accept;
  logic        elide;

  assign wr_ready    = (state_q == StIdle);
  assign drain_req   = (state_q == StDrain);
  assign flush_req   = (state_q == StFlush);
  assign busy        = (state_q != StIdle);
  assign wr_done     = wr_done_q;
  assign wr_reject   = wr_reject_q;
  assign timeout_err = timeout_err_q;
  assign accept      = wr_valid && wr_ready;

`ifdef HARVOS_SATP_FLUSH_ELIDE_EN
  assign elide = (wr_data == csr_satp_q);
`else
  assign elide = 1'b0;
`endif

  always_comb begin
    state_d       = state_q;
    pending_d     = pending_q;
    csr_d         = csr_satp_q;
    wait_cnt_d    = wait_cnt_q;
    wr_done_d     = 1'b0;
    wr_reject_d   = 1'b0;
    timeout_err_d = timeout_err_q;

    unique case (state_q)
      StIdle: begin
        if (accept) begin
          // Bare mode (MODE bit clear) is refused outright.
          if (!wr_data[31]) begin
            wr_reject_d = 1'b1;
          end else begin
            pending_d  = wr_data;
            wait_cnt_d = '0;
            state_d    = elide ? StCommit : StDrain;
          end
        end
      end
      StDrain: begin
        if (drain_ack) begin
          wait_cnt_d = '0;
          state_d    = StFlush;
        end else if (wait_cnt_q == WaitLimit) begin
          wr_reject_d   = 1'b1;
          timeout_err_d = 1'b1;
          state_d       = StIdle;
        end else begin
          wait_cnt_d = wait_cnt_q + 16'd1;
        end
      end
      StFlush: begin
        if (flush_ack) begin
          wait_cnt_d = '0;
          state_d    = StCommit;
        end else if (wait_cnt_q == WaitLimit) begin
          wr_reject_d   = 1'b1;
          timeout_err_d = 1'b1;
          state_d       = StIdle;
        end else begin
          wait_cnt_d = wait_cnt_q + 16'd1;
        end
      end
      StCommit: begin
        csr_d     = pending_q;
        wr_done_d = 1'b1;
        state_d   = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= StIdle;
      // MODE bit is kept set even if the parameter is misconfigured.
      csr_satp_q    <= RESET_SATP | 32'h8000_0000;
      pending_q     <= '0;
      wait_cnt_q    <= '0;
      wr_done_q     <= 1'b0;
      wr_reject_q   <= 1'b0;
      timeout_err_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      csr_satp_q    <= csr_d;
      pending_q     <= pending_d;
      wait_cnt_q    <= wait_cnt_d;
      wr_done_q     <= wr_done_d;
      wr_reject_q   <= wr_reject_d;
      timeout_err_q <= timeout_err_d;
    end
  end

endmodule

// File: tb/tb_harvos_satp_update_ctrl.sv
// Self-checking bench for harvos_satp_update_ctrl; a scoreboard holds the expected outcome of each
// write and a monitor compares it when wr_done or wr_reject pulses.
module tb_harvos_satp_update_ctrl;

  localparam logic [31:0] ResetSatp = 32'h8000_0000;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        wr_valid = 1'b0;
  logic        wr_ready;
  logic [31:0] wr_data = '0;
  logic        wr_done;
  logic        wr_reject;
  logic        drain_req;
  logic        drain_ack = 1'b1;
  logic        flush_req;
  logic        flush_ack = 1'b1;
  logic [31:0] csr_satp_q;
  logic        busy;
  logic        timeout_err;

  typedef struct {
    logic        is_done;
    logic [31:0] csr;
  } outcome_t;

  outcome_t    sb_q[$];
  int          checks = 0;
  int          errors = 0;
  logic [31:0] model_csr = ResetSatp;

  harvos_satp_update_ctrl #(
    .RESET_SATP    (ResetSatp),
    .TIMEOUT_CYCLES(4)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .wr_valid   (wr_valid),
    .wr_ready   (wr_ready),
    .wr_data    (wr_data),
    .wr_done    (wr_done),
    .wr_reject  (wr_reject),
    .drain_req  (drain_req),
    .drain_ack  (drain_ack),
    .flush_req  (flush_req),
    .flush_ack  (flush_ack),
    .csr_satp_q (csr_satp_q),
    .busy       (busy),
    .timeout_err(timeout_err)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (wr_done === 1'b1 || wr_reject === 1'b1) begin
      outcome_t exp_o;
      checks++;
      if (sb_q.size() == 0) begin
        errors++;
        $display("FAIL sb_unexpected: done=%b reject=%b with empty scoreboard", wr_done, wr_reject);
      end else begin
        exp_o = sb_q.pop_front();
        if (wr_done !== exp_o.is_done) begin
          errors++;
          $display("FAIL sb_kind: wr_done=%b required %b", wr_done, exp_o.is_done);
        end
        checks++;
        if (csr_satp_q !== exp_o.csr) begin
          errors++;
          $display("FAIL sb_csr: csr_satp_q=%h required %h", csr_satp_q, exp_o.csr);
        end
      end
    end
  end

  // Drives one write and measures drain/flush request cycles and the number of edges from
  // acceptance until wr_done or wr_reject is visible (-1 if it never appears).
  task automatic run_write(input logic [31:0] data, output int nd, output int nf, output int lat);
    nd  = 0;
    nf  = 0;
    lat = -1;
    @(negedge clk);
    wr_valid = 1'b1;
    wr_data  = data;
    @(posedge clk);
    #1 wr_valid = 1'b0;
    for (int i = 1; i <= 40; i++) begin
      @(negedge clk);
      if (drain_req) nd++;
      if (flush_req) nf++;
      if (wr_done || wr_reject) begin
        lat = i - 1;
        break;
      end
    end
  endtask

  task automatic test_reset;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    checks++;
    if (csr_satp_q !== 32'h8000_0000) begin
      errors++; $display("FAIL reset_csr: got %h required 80000000", csr_satp_q);
    end
    checks++;
    if (wr_ready !== 1'b1) begin errors++; $display("FAIL reset_ready: got %b required 1", wr_ready); end
    checks++;
    if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b required 0", busy); end
    checks++;
    if (timeout_err !== 1'b0) begin
      errors++; $display("FAIL reset_timeout_err: got %b required 0", timeout_err);
    end
  endtask

  task automatic test_basic_write;
    int nd, nf, lat;
    drain_ack = 1'b1;
    flush_ack = 1'b1;
    model_csr = 32'h8000_1234;
    sb_q.push_back('{is_done: 1'b1, csr: model_csr});
    run_write(32'h8000_1234, nd, nf, lat);
    checks++;
    if (nd != 1) begin errors++; $display("FAIL basic_drain_cycles: got %0d required 1", nd); end
    checks++;
    if (nf != 1) begin errors++; $display("FAIL basic_flush_cycles: got %0d required 1", nf); end
    checks++;
    if (lat != 3) begin errors++; $display("FAIL basic_latency: got %0d required 3", lat); end
    checks++;
    if (busy !== 1'b0) begin errors++; $display("FAIL basic_busy_after: got %b required 0", busy); end
  endtask

  task automatic test_bare_reject;
    int nd, nf, lat;
    sb_q.push_back('{is_done: 1'b0, csr: model_csr});
    run_write(32'h0000_1234, nd, nf, lat);
    checks++;
    if (lat != 0) begin errors++; $display("FAIL bare_latency: got %0d required 0", lat); end
    checks++;
    if (nd != 0) begin errors++; $display("FAIL bare_drain: got %0d required 0", nd); end
    checks++;
    if (busy !== 1'b0) begin errors++; $display("FAIL bare_busy: got %b required 0", busy); end
  endtask

  task automatic test_timeout;
    int nd, nf, lat;
    drain_ack = 1'b1;
    flush_ack = 1'b0;
    sb_q.push_back('{is_done: 1'b0, csr: model_csr});
    run_write(32'h8000_0001, nd, nf, lat);
    checks++;
    if (nf != 4) begin errors++; $display("FAIL timeout_flush_cycles: got %0d required 4", nf); end
    checks++;
    if (lat != 5) begin errors++; $display("FAIL timeout_latency: got %0d required 5", lat); end
    checks++;
    if (timeout_err !== 1'b1) begin
      errors++; $display("FAIL timeout_err_set: got %b required 1", timeout_err);
    end
    checks++;
    if (flush_req !== 1'b0) begin errors++; $display("FAIL timeout_flush_req: got %b required 0", flush_req); end
    flush_ack = 1'b1;
    model_csr = 32'h8000_5678;
    sb_q.push_back('{is_done: 1'b1, csr: model_csr});
    run_write(32'h8000_5678, nd, nf, lat);
    checks++;
    if (lat != 3) begin errors++; $display("FAIL timeout_recover_latency: got %0d required 3", lat); end
    checks++;
    if (timeout_err !== 1'b1) begin
      errors++; $display("FAIL timeout_err_sticky: got %b required 1", timeout_err);
    end
  endtask

  task automatic test_back_to_back;
    int nd, nf, lat;
    for (int k = 0; k < 2; k++) begin
      model_csr = 32'h8000_0A00 + 32'(k);
      sb_q.push_back('{is_done: 1'b1, csr: model_csr});
      run_write(model_csr, nd, nf, lat);
      checks++;
      if (lat != 3) begin errors++; $display("FAIL b2b_latency[%0d]: got %0d required 3", k, lat); end
    end
  endtask

  task automatic test_reset_mid_flush;
    drain_ack = 1'b1;
    flush_ack = 1'b0;
    @(negedge clk);
    wr_valid = 1'b1;
    wr_data  = 32'h8000_9999;
    @(posedge clk);
    #1 wr_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    checks++;
    if (flush_req !== 1'b1) begin errors++; $display("FAIL rstmid_in_flush: got %b required 1", flush_req); end
    rst = 1'b1;
    @(posedge clk);
    #1;
    checks++;
    if (flush_req !== 1'b0) begin errors++; $display("FAIL rstmid_flush_req: got %b required 0", flush_req); end
    checks++;
    if (busy !== 1'b0) begin errors++; $display("FAIL rstmid_busy: got %b required 0", busy); end
    checks++;
    if (csr_satp_q !== ResetSatp) begin
      errors++; $display("FAIL rstmid_csr: got %h required %h", csr_satp_q, ResetSatp);
    end
    checks++;
    if (wr_done !== 1'b0) begin errors++; $display("FAIL rstmid_done: got %b required 0", wr_done); end
    rst = 1'b0;
    flush_ack = 1'b1;
    model_csr = ResetSatp;
  endtask

  task automatic test_elide;
    int nd, nf, lat;
    int exp_n, exp_lat;
`ifdef HARVOS_SATP_FLUSH_ELIDE_EN
    exp_n   = 0;
    exp_lat = 1;
`else
    exp_n   = 1;
    exp_lat = 3;
`endif
    sb_q.push_back('{is_done: 1'b1, csr: model_csr});
    run_write(model_csr, nd, nf, lat);
    checks++;
    if (nd != exp_n) begin errors++; $display("FAIL same_drain: got %0d required %0d", nd, exp_n); end
    checks++;
    if (nf != exp_n) begin errors++; $display("FAIL same_flush: got %0d required %0d", nf, exp_n); end
    checks++;
    if (lat != exp_lat) begin
      errors++; $display("FAIL same_latency: got %0d required %0d", lat, exp_lat);
    end
    model_csr = 32'h8000_00AB;
    sb_q.push_back('{is_done: 1'b1, csr: model_csr});
    run_write(model_csr, nd, nf, lat);
    checks++;
    if (nd != 1 || nf != 1) begin
      errors++; $display("FAIL diff_sequence: drain=%0d flush=%0d required 1 1", nd, nf);
    end
    checks++;
    if (lat != 3) begin errors++; $display("FAIL diff_latency: got %0d required 3", lat); end
  endtask

  initial begin
    test_reset();
    test_basic_write();
    test_bare_reject();
    test_timeout();
    test_back_to_back();
    test_reset_mid_flush();
    test_elide();
    repeat (3) @(negedge clk);
    checks++;
    if (sb_q.size() != 0) begin
      errors++; $display("FAIL sb_leftover: %0d outcomes pending, required 0", sb_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/harvos_satp_update_ctrl.md
HARVOS_SATP_UPDATE_CTRL -- requirements
Module: harvos_satp_update_ctrl

Interface
REQ-001 Parameter RESET_SATP, default 32'h8000_0000, is the reset value of csr_satp_q; bit 31 SHALL be 1.
REQ-002 Parameter TIMEOUT_CYCLES, default 255, is the maximum number of wait cycles per handshake phase (range 1..65535).
REQ-003 clk  in  1  single clock; all logic SHALL be on its rising edge.
REQ-004 rst  in  1  reset, synchronous, active-high.
REQ-005 wr_valid  in  1  CSR write to satp requested.
REQ-006 wr_ready  out  1  controller can accept a write.
REQ-007 wr_data  in  32  proposed satp value.
REQ-008 wr_done  out  1  one-cycle pulse: write committed.
REQ-009 wr_reject  out  1  one-cycle pulse: write refused (Bare mode or timeout).
REQ-010 drain_req  out  1  request to drain in-flight memory ops.
REQ-011 drain_ack  in  1  pipeline drained.
REQ-012 flush_req  out  1  request a TLB flush.
REQ-013 flush_ack  in  1  TLB flush complete.
REQ-014 csr_satp_q  out  32  architectural satp value.
REQ-015 busy  out  1  high in any state other than IDLE.
REQ-016 timeout_err  out  1  sticky: a handshake phase timed out.

Function
REQ-017 The FSM SHALL have the states IDLE, DRAIN, FLUSH and COMMIT.
REQ-018 wr_ready SHALL be 1 only in IDLE; a write is accepted when wr_valid && wr_ready.
REQ-019 On acceptance with wr_data[31]==0, the FSM SHALL stay in IDLE, pulse wr_reject in the next cycle, and leave csr_satp_q unchanged.
REQ-020 On acceptance with wr_data[31]==1, the block SHALL latch wr_data into a pending register and enter DRAIN.
REQ-021 In DRAIN, drain_req SHALL be 1; when drain_ack is sampled 1, the FSM SHALL enter FLUSH.
REQ-022 In FLUSH, flush_req SHALL be 1; when flush_ack is sampled 1, the FSM SHALL enter COMMIT.
REQ-023 In COMMIT, csr_satp_q SHALL load the pending value, wr_done SHALL pulse in the same cycle, and the FSM SHALL return to IDLE.
REQ-024 With acks already high, the minimum latency SHALL be: accept at edge T, csr_satp_q updated and wr_done visible after edge T+3.
REQ-025 A wait counter SHALL clear on entry to DRAIN or FLUSH and increment each cycle without ack.
REQ-026 If the wait counter reaches TIMEOUT_CYCLES, the FSM SHALL go to IDLE, pulse wr_reject, set timeout_err, deassert the requests, and leave csr_satp_q unchanged.
REQ-027 If an ack arrives in the same cycle that the counter reaches the limit, the ack SHALL win.
REQ-028 drain_ack and flush_ack SHALL be ignored in any state that does not request them.
REQ-029 csr_satp_q[31] SHALL be 1 in every cycle.

Reset
REQ-030 When rst is 1 at a clock edge, the block SHALL enter IDLE, set csr_satp_q to RESET_SATP, and clear wr_done, wr_reject, drain_req, flush_req, busy, timeout_err, the wait counter and the pending register.
REQ-031 A reset in the middle of an update SHALL discard the pending value without a commit or reject pulse.
REQ-032 timeout_err SHALL be cleared only by reset.

Configuration
REQ-033 With the macro HARVOS_SATP_FLUSH_ELIDE_EN defined, an accepted valid write equal to csr_satp_q SHALL skip DRAIN and FLUSH, go directly to COMMIT, and pulse wr_done 1 cycle after acceptance.
REQ-034 Without HARVOS_SATP_FLUSH_ELIDE_EN, every accepted valid write SHALL pass through DRAIN and FLUSH.

Verification
REQ-035 Reset, then idle -> csr_satp_q=32'h8000_0000, wr_ready=1, busy=0, timeout_err=0.
REQ-036 Write 32'h8000_1234 with drain_ack and flush_ack tied to 1 -> drain_req for 1 cycle, then flush_req for 1 cycle, then wr_done; csr_satp_q=32'h8000_1234 exactly 3 cycles after acceptance.
REQ-037 Write 32'h0000_1234 -> wr_reject pulse next cycle, no drain_req, csr_satp_q unchanged.
REQ-038 Write 32'h8000_0001 with flush_ack held 0 and TIMEOUT_CYCLES=4 -> wr_reject after 4 FLUSH cycles, timeout_err=1, csr_satp_q unchanged; a second write then commits normally and timeout_err stays 1.
REQ-039 rst asserted during FLUSH -> next cycle: IDLE, flush_req=0, csr_satp_q=RESET_SATP, no wr_done.
REQ-040 With HARVOS_SATP_FLUSH_ELIDE_EN, rewrite of the current value 32'h8000_0000 -> no drain_req or flush_req, wr_done 1 cycle after acceptance; a differing value -> full sequence.
